multicycle_cond_controller: RTL and testbench
=============================================

Name: multicycle_cond_controller

Overview:
- Main control FSM of the multicycle ARM-subset processor.
- Sequences every instruction through fetch, decode, execute, memory and writeback.
- Decodes Op/Funct into datapath mux selects and ALU control, and owns the architectural NZCV flags register.
- Evaluates the condition field against the registered flags using the team's 16-code ARM condition table, and gates all architectural writes with the result.

Parameters:
- none (datapath widths fixed by ISA).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Cond  input  4  Instr[31:28].
- Op  input  2  Instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
- Funct  input  6  Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S (data-processing) or L (memory).
- Rd  input  4  Instr[15:12].
- ALUFlags  input  4  {N,Z,C,V} from the ALU, same cycle.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address select: 0=PC, 1=Result.
- MemWrite  output  1  data memory write enable.
- IRWrite  output  1  instruction register enable.
- RegWrite  output  1  register file write enable.
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA  output  1  0=RD1 reg, 1=PC.
- ALUSrcB  output  2  00=RD2 reg, 01=ExtImm, 10=const 4.
- ImmSrc  output  2  equals Op.
- RegSrc  output  2  [1]=(Op==01), [0]=(Op==10).
- ALUControl  output  2  00 add, 01 sub, 10 and, 11 orr.
- Flags  output  4  registered {N,Z,C,V}.
- State  output  4  current state encoding, for debug.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
  - Codes 10–15 are unreachable; if entered, go to FETCH.
- Reset (async):
  - State=FETCH, Flags=0000, CondExL=0.
  - While Reset is high, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR if Op=01; →EXECI if Op=00 and I=1; →EXECR if Op=00 and I=0; →BRANCH if Op=10; →FETCH if Op=11.
  - MEMADR→MEMRD if L=1, else →MEMWR.
  - MEMRD→MEMWB.
  - MEMWB, MEMWR, ALUWB and BRANCH each →FETCH.
  - EXECR and EXECI each →ALUWB.
- Condition evaluation:
  - CondEx is combinational from Cond and the registered Flags, per the standard 16-code table. Cond=1110 is always true; Cond=1111 is always false.
  - CondExL is loaded with CondEx at the end of DECODE and is held until the next DECODE.
  - All gating below uses CondExL. A flag update made during execute therefore cannot change the same instruction's writeback.
- Per-state outputs (any output not listed is 0):
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10, IRWrite=1, PCWrite=1 (ungated).
  - DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=00.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=CondExL.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=CondExL.
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALUControl=decoded.
  - EXECI: ALUSrcA=0, ALUSrcB=01, ALUControl=decoded.
  - ALUWB: ResultSrc=00, RegWrite=CondExL & ~NoWrite.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ALUControl=00, ResultSrc=10, PCWrite=CondExL.
- PC writeback: in MEMWB or ALUWB with Rd=1111, PCWrite=CondExL as well as RegWrite.
- cmd decode (data-processing, Op=00):
  - ADD 0100→00; SUB 0010→01; AND 0000→10; ORR 1100→11; CMP 1010→01 with NoWrite=1.
  - Any other cmd→00 with NoWrite=1 (acts as NOP).
- Flag write:
  - FlagW[1]=S.
  - FlagW[0]=S & cmd∈{ADD,SUB,CMP}; CMP forces both FlagW bits to 1 regardless of S.
  - On the clock edge leaving EXECR/EXECI, if CondExL: FlagW[1] loads Flags[3:2]←ALUFlags[3:2], and FlagW[0] loads Flags[1:0]←ALUFlags[1:0].
  - Flags change in no other state.
- Reset mid-instruction: the instruction is abandoned and no write enable pulses after Reset rises. After Reset falls, the first clock edge moves FETCH→DECODE, loading the IR with the instruction at the current PC.

Test Plan:
- Reset released, Op=00, I=0, cmd=0100, S=1, Cond=1110, ALUFlags=0110 → State 0,1,6,8,0.
  - FETCH: PCWrite=IRWrite=1. EXECR: ALUControl=00. ALUWB: RegWrite=1.
  - Flags=0110 after EXECR.
- LDR (Op=01, L=1, Cond=1110) → 0,1,2,3,4,0; MEMRD: AdrSrc=1; MEMWB: ResultSrc=01 and RegWrite=1. STR (L=0) → 0,1,2,5,0; MEMWR: MemWrite=1; RegWrite never asserted.
- CMP (cmd=1010, S=0) with ALUFlags=0100, then BEQ (Op=10, Cond=0000) → Flags=0100; BRANCH: PCWrite=1. With ALUFlags=0000 instead: BRANCH PCWrite=0.
- ADDNE (Cond=0001) while Flags.Z=1, S=1, ALUFlags=1000 → ALUWB RegWrite=0, and Flags stay 0100.
- Rd=1111 ADD, Cond=1110 → ALUWB asserts both RegWrite and PCWrite. Op=11 → 0,1,0 with no write enables beyond FETCH. Cond=1111 → all gated writes 0.
- Reset asserted while State=5 (MEMWR) → State=0 immediately; MemWrite=0; Flags=0000.

Source files
------------

// File: rtl/multicycle_cond_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// The master side is the controller; the slave side is the datapath.
interface multicycle_cond_controller_if;
   logic [3:0] Cond;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ImmSrc;
   logic [1:0] RegSrc;
   logic [1:0] ALUControl;
   logic [3:0] Flags;
   logic [3:0] State;

   modport master (
      input  Cond, Op, Funct, Rd, ALUFlags,
      output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, Flags, State
   );

   modport slave (
      output Cond, Op, Funct, Rd, ALUFlags,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, Flags, State
   );
endinterface

// File: rtl/multicycle_cond_controller.sv
// Main control FSM of the multicycle ARM-subset core: sequences each instruction,
// decodes datapath controls, owns NZCV and gates architectural writes by condition.
module multicycle_cond_controller (
   input logic                           CLK,
   input logic                           Reset,
   multicycle_cond_controller_if.master  bus
);
   typedef enum logic [3:0] {
      FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD  = 4'd3, MEMWB = 4'd4,
      MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7, ALUWB  = 4'd8, BRANCH = 4'd9
   } state_t;

   state_t     state;
   logic [3:0] flags;
   logic       cond_ex;
   logic       cond_ex_l;
   logic [3:0] cmd;
   logic [1:0] alu_dec;
   logic       no_write;
   logic [1:0] flag_w;
   logic       n, z, c, v;

   assign cmd          = bus.Funct[4:1];
   assign {n, z, c, v} = flags;

   // Condition check against the architectural (registered) flags
   always_comb begin
      cond_ex = 1'b0;
      case (bus.Cond)
         4'b0000: cond_ex = z;
         4'b0001: cond_ex = ~z;
         4'b0010: cond_ex = c;
         4'b0011: cond_ex = ~c;
         4'b0100: cond_ex = n;
         4'b0101: cond_ex = ~n;
         4'b0110: cond_ex = v;
         4'b0111: cond_ex = ~v;
         4'b1000: cond_ex = c & ~z;
         4'b1001: cond_ex = ~(c & ~z);
         4'b1010: cond_ex = (n == v);
         4'b1011: cond_ex = (n != v);
         4'b1100: cond_ex = ~z & (n == v);
         4'b1101: cond_ex = ~(~z & (n == v));
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // Data-processing command decode; unknown commands become flag-only NOPs
   always_comb begin
      alu_dec  = 2'b00;
      no_write = 1'b0;
      flag_w   = {bus.Funct[0], 1'b0};
      case (cmd)
         4'b0100: flag_w[0] = bus.Funct[0];
         4'b0010: begin alu_dec = 2'b01; flag_w[0] = bus.Funct[0]; end
         4'b0000: alu_dec = 2'b10;
         4'b1100: alu_dec = 2'b11;
         4'b1010: begin alu_dec = 2'b01; no_write = 1'b1; flag_w = 2'b11; end
         default: no_write = 1'b1;
      endcase
   end

   // State, latched condition and flags register
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state     <= FETCH;
         flags     <= 4'b0000;
         cond_ex_l <= 1'b0;
      end else begin
         case (state)
            FETCH:  state <= DECODE;
            DECODE: begin
               cond_ex_l <= cond_ex;
               case (bus.Op)
                  2'b00:   state <= bus.Funct[5] ? EXECI : EXECR;
                  2'b01:   state <= MEMADR;
                  2'b10:   state <= BRANCH;
                  default: state <= FETCH;
               endcase
            end
            MEMADR: state <= bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD:  state <= MEMWB;
            EXECR, EXECI: begin
               state <= ALUWB;
               if (cond_ex_l && flag_w[1]) flags[3:2] <= bus.ALUFlags[3:2];
               if (cond_ex_l && flag_w[0]) flags[1:0] <= bus.ALUFlags[1:0];
            end
            default: state <= FETCH;
         endcase
      end
   end

   logic       pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a;
   logic [1:0] result_src, alu_src_b, alu_control;
   logic       rd_is_pc;

   assign rd_is_pc = (bus.Rd == 4'hF);

   // Per-state datapath controls; write enables are held low during reset
   always_comb begin
      pc_write    = 1'b0;
      adr_src     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      result_src  = 2'b00;
      alu_src_b   = 2'b00;
      alu_control = 2'b00;
      case (state)
         FETCH: begin
            alu_src_a = 1'b1; alu_src_b = 2'b10; result_src = 2'b10;
            ir_write  = 1'b1; pc_write  = 1'b1;
         end
         DECODE: begin
            alu_src_a = 1'b1; alu_src_b = 2'b10; result_src = 2'b10;
         end
         MEMADR: alu_src_b = 2'b01;
         MEMRD:  adr_src = 1'b1;
         MEMWB: begin
            result_src = 2'b01;
            reg_write  = cond_ex_l;
            pc_write   = cond_ex_l & rd_is_pc;
         end
         MEMWR: begin adr_src = 1'b1; mem_write = cond_ex_l; end
         EXECR: alu_control = alu_dec;
         EXECI: begin alu_src_b = 2'b01; alu_control = alu_dec; end
         ALUWB: begin
            reg_write = cond_ex_l & ~no_write;
            pc_write  = cond_ex_l & rd_is_pc;
         end
         BRANCH: begin
            alu_src_b = 2'b01; result_src = 2'b10; pc_write = cond_ex_l;
         end
         default: ;
      endcase
      if (Reset) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         mem_write = 1'b0;
         reg_write = 1'b0;
      end
   end

   assign bus.PCWrite    = pc_write;
   assign bus.AdrSrc     = adr_src;
   assign bus.MemWrite   = mem_write;
   assign bus.IRWrite    = ir_write;
   assign bus.RegWrite   = reg_write;
   assign bus.ResultSrc  = result_src;
   assign bus.ALUSrcA    = alu_src_a;
   assign bus.ALUSrcB    = alu_src_b;
   assign bus.ALUControl = alu_control;
   assign bus.ImmSrc     = bus.Op;
   assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
   assign bus.Flags      = flags;
   assign bus.State      = state;
endmodule

// File: tb/tb_multicycle_cond_controller.sv
// Bench for multicycle_cond_controller: directed instruction scenarios followed by
// random instructions, each checked against an instruction-level reference model.
module tb_multicycle_cond_controller;
   logic CLK = 1'b0;
   logic Reset;

   multicycle_cond_controller_if bus ();
   multicycle_cond_controller dut (.CLK(CLK), .Reset(Reset), .bus(bus));

   always #5 CLK = ~CLK;

   int unsigned total  = 0;
   int unsigned passed = 0;
   logic [3:0]  mflags = 4'b0000;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // ARM condition: pairs of codes share a base test, odd code inverts it
   function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
      logic fn, fz, fc, fv, base;
      {fn, fz, fc, fv} = f;
      if (c == 4'hF) return 1'b0;
      case (c[3:1])
         3'd0:    base = fz;
         3'd1:    base = fc;
         3'd2:    base = fn;
         3'd3:    base = fv;
         3'd4:    base = fc & ~fz;
         3'd5:    base = (fn == fv);
         3'd6:    base = ~fz & (fn == fv);
         default: base = 1'b1;
      endcase
      return base ^ c[0];
   endfunction

   // Drives one instruction from FETCH back to FETCH and checks every cycle
   task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                            input logic [3:0] rd, input logic [3:0] af);
      logic       ct, is_add, is_sub, is_and, is_orr, is_cmp, writes;
      logic [3:0] cmd, s, exp_we;
      logic [1:0] exp_alu;
      logic [3:0] path [$];
      bus.Cond = c; bus.Op = op; bus.Funct = fn; bus.Rd = rd; bus.ALUFlags = af;
      #1;
      ct     = cond_true(c, mflags);
      cmd    = fn[4:1];
      is_add = (cmd == 4'b0100);
      is_sub = (cmd == 4'b0010);
      is_and = (cmd == 4'b0000);
      is_orr = (cmd == 4'b1100);
      is_cmp = (cmd == 4'b1010);
      writes = is_add | is_sub | is_and | is_orr;
      exp_alu = is_orr ? 2'b11 : is_and ? 2'b10 : (is_sub | is_cmp) ? 2'b01 : 2'b00;
      path = '{4'd0, 4'd1};
      case (op)
         2'b00: begin path.push_back(fn[5] ? 4'd7 : 4'd6); path.push_back(4'd8); end
         2'b01: begin
            path.push_back(4'd2);
            if (fn[0]) begin path.push_back(4'd3); path.push_back(4'd4); end
            else path.push_back(4'd5);
         end
         2'b10: path.push_back(4'd9);
         default: ;
      endcase
      foreach (path[i]) begin
         s = path[i];
         if (i > 0) begin @(posedge CLK); #1; end
         chk("state", 8'(bus.State), 8'(s));
         exp_we[3] = (s == 4'd0) | (s == 4'd9 & ct) | ((s == 4'd4 | s == 4'd8) & ct & rd == 4'hF);
         exp_we[2] = (s == 4'd0);
         exp_we[1] = (s == 4'd5) & ct;
         exp_we[0] = ((s == 4'd4) | (s == 4'd8 & writes)) & ct;
         chk("write_enables", 8'({bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}), 8'(exp_we));
         chk("adr_src", 8'(bus.AdrSrc), 8'(s == 4'd3 || s == 4'd5));
         if (s == 4'd6 || s == 4'd7) chk("alu_control", 8'(bus.ALUControl), 8'(exp_alu));
         if (s == 4'd4) chk("result_src_memwb", 8'(bus.ResultSrc), 8'd1);
      end
      @(posedge CLK); #1;
      if (op == 2'b00 && ct) begin
         if (fn[0] | is_cmp) mflags[3:2] = af[3:2];
         if (is_cmp | (fn[0] & (is_add | is_sub))) mflags[1:0] = af[1:0];
      end
      chk("flags", 8'(bus.Flags), 8'(mflags));
      chk("back_to_fetch", 8'(bus.State), 8'd0);
      chk("imm_src", 8'(bus.ImmSrc), 8'(op));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b1;
      bus.Cond = 4'hE; bus.Op = 2'b00; bus.Funct = 6'b0_0100_1; bus.Rd = 4'd2; bus.ALUFlags = 4'b0110;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset_state", 8'(bus.State), 8'd0);
      chk("reset_write_enables", 8'({bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}), 8'd0);
      chk("reset_flags", 8'(bus.Flags), 8'd0);
      @(negedge CLK);
      Reset = 1'b0;

      run_instr(4'hE, 2'b00, 6'b0_0100_1, 4'd2, 4'b0110);    // ADDS
      run_instr(4'hE, 2'b01, 6'b0_0000_1, 4'd3, 4'b0000);    // LDR
      run_instr(4'hE, 2'b01, 6'b0_0000_0, 4'd3, 4'b0000);    // STR
      run_instr(4'hE, 2'b00, 6'b0_1010_0, 4'd0, 4'b0100);    // CMP -> Z
      run_instr(4'h0, 2'b10, 6'b0_0000_0, 4'd0, 4'b0000);    // BEQ taken
      run_instr(4'hE, 2'b00, 6'b0_1010_0, 4'd0, 4'b0000);    // CMP -> clear
      run_instr(4'h0, 2'b10, 6'b0_0000_0, 4'd0, 4'b0000);    // BEQ not taken
      run_instr(4'hE, 2'b00, 6'b0_1010_0, 4'd0, 4'b0100);    // CMP -> Z
      run_instr(4'h1, 2'b00, 6'b0_0100_1, 4'd4, 4'b1000);    // ADDNES suppressed
      run_instr(4'hE, 2'b00, 6'b1_0100_0, 4'hF, 4'b0000);    // ADD to PC
      run_instr(4'hE, 2'b11, 6'b0_0100_1, 4'd1, 4'b1111);    // undefined op
      run_instr(4'hF, 2'b00, 6'b0_0100_1, 4'hF, 4'b1111);    // never: ADD
      run_instr(4'hF, 2'b01, 6'b0_0000_1, 4'hF, 4'b0000);    // never: LDR
      run_instr(4'hF, 2'b01, 6'b0_0000_0, 4'd1, 4'b0000);    // never: STR
      run_instr(4'hF, 2'b10, 6'b0_0000_0, 4'd1, 4'b0000);    // never: B

      // Reset while a store is in MEMWR
      bus.Cond = 4'hE; bus.Op = 2'b01; bus.Funct = 6'b0_0000_0; bus.Rd = 4'd1;
      repeat (3) @(posedge CLK);
      #1;
      chk("pre_reset_memwr", 8'(bus.State), 8'd5);
      chk("pre_reset_memwrite", 8'(bus.MemWrite), 8'd1);
      Reset = 1'b1;
      #1;
      chk("midreset_state", 8'(bus.State), 8'd0);
      chk("midreset_write_enables", 8'({bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}), 8'd0);
      chk("midreset_flags", 8'(bus.Flags), 8'd0);
      @(posedge CLK); #1;
      chk("held_reset_state", 8'(bus.State), 8'd0);
      @(negedge CLK);
      Reset = 1'b0;
      mflags = 4'b0000;
      run_instr(4'hE, 2'b00, 6'b1_0010_1, 4'd5, 4'b1011);    // SUBS after reset

      for (int k = 0; k < 150; k++) begin
         run_instr(4'($urandom), 2'($urandom), 6'($urandom),
                   ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom), 4'($urandom));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
